// File: rtl/a23_copro_pkg.sv
// a23_copro_pkg: shared coprocessor-15 operation encodings, register numbers and fault record layout.
package a23_copro_pkg;
  localparam logic [1:0] COPRO_MRC = 2'd1;
  localparam logic [1:0] COPRO_MCR = 2'd2;
  localparam logic [3:0] CRN_ID = 4'd0;
  localparam logic [3:0] CRN_FLUSH = 4'd1;
  localparam logic [3:0] CRN_CACHE = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
  localparam logic [3:0] CRN_FAULT_STATUS = 4'd6;
  localparam logic [3:0] CRN_FAULT_ADDRESS = 4'd7;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4156_0300;
  typedef struct packed {
    logic [7:0] status;
    logic [31:0] address;
  } fault_t;
endpackage

// File: rtl/a23_copro_fault_fifo.sv
// a23_copro_fault_fifo: fault record FIFO; pops on empty are ignored, pushes on full only land alongside a pop.
module a23_copro_fault_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= data;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/a23_copro15_ctrl.sv
// a23_copro15_ctrl: CP15 cache/region control with fault capture.
// Define A23_COPRO_FAULT_QUEUE_EN for a fault queue; otherwise a single last-fault register.
module a23_copro15_ctrl
  import a23_copro_pkg::*;
#(
  parameter int REGION_BITS = 32,
  parameter int FAULT_DEPTH = 4,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_fetch_stall,
  input  logic [1:0] i_copro_operation,
  input  logic [3:0] i_copro_crn,
  input  logic [31:0] i_copro_write_data,
  input  logic i_fault,
  input  logic [7:0] i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic i_cache_flush_ack,
  output logic [31:0] o_copro_read_data,
  output logic o_cache_enable,
  output logic o_cache_flush,
  output logic [REGION_BITS-1:0] o_cacheable_area,
  output logic o_fault_pending
);
  if (REGION_BITS < 1 || REGION_BITS > 32 || FAULT_DEPTH < 2 || FAULT_DEPTH > 16 ||
      (FAULT_DEPTH & (FAULT_DEPTH - 1)) != 0) begin : g_bad_param
    $error("a23_copro15_ctrl: parameter out of range");
  end
  logic run, mcr, mrc;
  logic [2:0] cache_control;
  logic [REGION_BITS-1:0] cacheable, updateable, disruptive;
  logic flush_pending, overflow, fault_pending;
  logic [3:0] count;
  fault_t head;
  logic [31:0] read_mux;
  assign run = !i_fetch_stall;
  assign mcr = run && i_copro_operation == COPRO_MCR;
  assign mrc = run && i_copro_operation == COPRO_MRC;
  always_comb begin
    read_mux = i_copro_crn == CRN_ID ? ID_VALUE :
               i_copro_crn == CRN_CACHE ? {29'd0, cache_control} :
               i_copro_crn == CRN_CACHEABLE ? 32'(cacheable) :
               i_copro_crn == CRN_UPDATEABLE ? 32'(updateable) :
               i_copro_crn == CRN_DISRUPTIVE ? 32'(disruptive) :
               i_copro_crn == CRN_FAULT_STATUS ? {overflow, 19'd0, count, head.status} :
               i_copro_crn == CRN_FAULT_ADDRESS ? head.address : 32'd0;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cache_control <= '0;
      cacheable <= '0;
      updateable <= '0;
      disruptive <= '0;
      o_copro_read_data <= '0;
    end else if (run) begin
      o_copro_read_data <= read_mux;
      if (mcr && i_copro_crn == CRN_CACHE) cache_control <= i_copro_write_data[2:0];
      if (mcr && i_copro_crn == CRN_CACHEABLE) cacheable <= i_copro_write_data[REGION_BITS-1:0];
      if (mcr && i_copro_crn == CRN_UPDATEABLE) updateable <= i_copro_write_data[REGION_BITS-1:0];
      if (mcr && i_copro_crn == CRN_DISRUPTIVE) disruptive <= i_copro_write_data[REGION_BITS-1:0];
    end
  end
  // A new flush request wins over a coincident ack; acks land even while stalled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) flush_pending <= 1'b0;
    else if (mcr && i_copro_crn == CRN_FLUSH) flush_pending <= 1'b1;
    else if (i_cache_flush_ack) flush_pending <= 1'b0;
  end
`ifdef A23_COPRO_FAULT_QUEUE_EN
  localparam int CW = $clog2(FAULT_DEPTH) + 1;
  logic push, pop, full, empty;
  logic [CW-1:0] fifo_count;
  logic [39:0] fifo_head;
  assign push = run && i_fault;
  assign pop = mrc && i_copro_crn == CRN_FAULT_ADDRESS && !empty;
  a23_copro_fault_fifo #(.WIDTH(40), .DEPTH(FAULT_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_reset),
    .push(push),
    .pop(pop),
    .data({i_fault_status, i_fault_address}),
    .head(fifo_head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
    else if (mcr && i_copro_crn == CRN_FAULT_STATUS) overflow <= 1'b0;
  end
  assign head = fault_t'(fifo_head);
  assign count = 4'(fifo_count);
  assign fault_pending = !empty;
`else
  fault_t fault_reg;
  logic pending;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fault_reg <= '0;
      pending <= 1'b0;
    end else if (run && i_fault) begin
      fault_reg <= '{status: i_fault_status, address: i_fault_address};
      pending <= 1'b1;
    end else if (mcr && i_copro_crn == CRN_FAULT_STATUS) begin
      pending <= 1'b0;
    end
  end
  assign head = fault_reg;
  assign overflow = 1'b0;
  assign count = 4'd0;
  assign fault_pending = pending;
`endif
  assign o_cache_enable = cache_control[0];
  assign o_cache_flush = flush_pending;
  assign o_cacheable_area = cacheable;
  assign o_fault_pending = fault_pending;
endmodule

// File: tb/tb_a23_copro15_ctrl.sv
// tb_a23_copro15_ctrl: directed and random stimulus against a queue-based reference model.
module tb_a23_copro15_ctrl;
  localparam int RB = 16;
  localparam int FD = 4;
  localparam logic [31:0] ID = 32'h4156_0300;
  logic clk = 1'b0;
  logic rst, stall, fault, ack;
  logic [1:0] op;
  logic [3:0] crn;
  logic [31:0] wdata, faddr, rdata;
  logic [7:0] fstat;
  logic cen, cflush, fpend;
  logic [RB-1:0] carea;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  a23_copro15_ctrl #(.REGION_BITS(RB), .FAULT_DEPTH(FD)) dut (
    .i_clk(clk), .i_reset(rst), .i_fetch_stall(stall), .i_copro_operation(op),
    .i_copro_crn(crn), .i_copro_write_data(wdata), .i_fault(fault),
    .i_fault_status(fstat), .i_fault_address(faddr), .i_cache_flush_ack(ack),
    .o_copro_read_data(rdata), .o_cache_enable(cen), .o_cache_flush(cflush),
    .o_cacheable_area(carea), .o_fault_pending(fpend)
  );
  logic [2:0] m_cc;
  logic [RB-1:0] m_area [3];
  bit m_flush, m_ovf, m_pend;
  logic [39:0] m_q [$];
  logic [39:0] m_sreg;
  logic [31:0] m_rd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [31:0] model_read(input logic [3:0] c);
    logic [39:0] h;
    h = m_q.size() > 0 ? m_q[0] : 40'd0;
    case (c)
      4'd0: return ID;
      4'd2: return {29'd0, m_cc};
      4'd3, 4'd4, 4'd5: return 32'(m_area[int'(c) - 3]);
`ifdef A23_COPRO_FAULT_QUEUE_EN
      4'd6: return {m_ovf, 19'd0, 4'(m_q.size()), h[39:32]};
      4'd7: return h[31:0];
`else
      4'd6: return {24'd0, m_sreg[39:32]};
      4'd7: return m_sreg[31:0];
`endif
      default: return 32'd0;
    endcase
  endfunction
  function automatic bit model_pending();
`ifdef A23_COPRO_FAULT_QUEUE_EN
    return m_q.size() > 0;
`else
    return m_pend;
`endif
  endfunction
  task automatic check_outputs(input string w);
    check({w, ":read_data"}, rdata, m_rd);
    check({w, ":cache_enable"}, 32'(cen), 32'(m_cc[0]));
    check({w, ":cache_flush"}, 32'(cflush), 32'(m_flush));
    check({w, ":cacheable_area"}, 32'(carea), 32'(m_area[0]));
    check({w, ":fault_pending"}, 32'(fpend), 32'(model_pending()));
  endtask
  task automatic model_reset();
    m_cc = '0;
    for (int i = 0; i < 3; i++) m_area[i] = '0;
    m_flush = 0; m_ovf = 0; m_pend = 0; m_sreg = '0; m_rd = '0;
    m_q.delete();
  endtask
  task automatic do_reset(input string w);
    op = 2'd0; crn = '0; wdata = '0; fault = 0; fstat = '0; faddr = '0; ack = 0; stall = 0;
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs(w);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic cycle(input string w, input logic [1:0] o, input logic [3:0] c, input logic [31:0] d,
                       input logic f, input logic [31:0] fa, input logic a, input logic s);
    bit is_mcr, pop, full, drop;
    op = o; crn = c; wdata = d; fault = f; fstat = fa[7:0] ^ 8'h5a; faddr = fa; ack = a; stall = s;
    is_mcr = o == 2'd2;
    if (!s) m_rd = model_read(c);
    if (!s && is_mcr && c == 4'd1) m_flush = 1;
    else if (a) m_flush = 0;
    if (!s) begin
      if (is_mcr && c == 4'd2) m_cc = d[2:0];
      if (is_mcr && c >= 4'd3 && c <= 4'd5) m_area[int'(c) - 3] = d[RB-1:0];
`ifdef A23_COPRO_FAULT_QUEUE_EN
      pop = o == 2'd1 && c == 4'd7 && m_q.size() > 0;
      full = m_q.size() == FD;
      drop = f && full && !pop;
      if (is_mcr && c == 4'd6) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (pop) void'(m_q.pop_front());
      if (f && !drop) m_q.push_back({fstat, fa});
`else
      if (f) begin
        m_sreg = {fstat, fa};
        m_pend = 1;
      end else if (is_mcr && c == 4'd6) m_pend = 0;
`endif
    end
    @(posedge clk);
    #1;
    check_outputs(w);
  endtask
  task automatic mcr(input string w, input logic [3:0] c, input logic [31:0] d);
    cycle(w, 2'd2, c, d, 0, 0, 0, 0);
  endtask
  task automatic mrc(input string w, input logic [3:0] c);
    cycle(w, 2'd1, c, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1'b1;
    do_reset("reset");
    mrc("id_read", 4'd0);
    check("id_value", rdata, ID);
    mcr("area_write", 4'd3, 32'hFFFF_0001);
    check("area_trunc", 32'(carea), 32'h0000_0001);
    mrc("area_read", 4'd3);
    mcr("cache_en", 4'd2, 32'hFFFF_FFFD);
    mrc("cache_read", 4'd2);
    mcr("flush_req", 4'd1, 0);
    for (int i = 0; i < 5; i++) cycle("flush_hold", 2'd0, 4'd0, 0, 0, 0, 0, 0);
    cycle("flush_merge_ack", 2'd2, 4'd1, 0, 0, 0, 1, 0);
    check("flush_still_set", 32'(cflush), 32'd1);
    cycle("flush_ack", 2'd0, 4'd0, 0, 0, 0, 1, 0);
    cycle("stray_ack", 2'd0, 4'd0, 0, 0, 0, 1, 0);
    mcr("flush_req2", 4'd1, 0);
    cycle("stall_ack", 2'd2, 4'd1, 0, 0, 0, 1, 1);
    do_reset("reset_drops_flush");
    cycle("late_ack", 2'd0, 4'd0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("fault_push", 2'd0, 4'd0, 0, 1, 32'h100 + i, 0, 0);
    mrc("fault_status", 4'd6);
    for (int i = 0; i < 5; i++) mrc("fault_pop", 4'd7);
    mcr("ovf_clear", 4'd6, 0);
    mrc("fault_status2", 4'd6);
    for (int i = 0; i < 4; i++) cycle("fill", 2'd0, 4'd0, 0, 1, 32'h200 + i, 0, 0);
    cycle("full_push_pop", 2'd1, 4'd7, 0, 1, 32'h300, 0, 0);
    mrc("full_status", 4'd6);
    cycle("ovf_push", 2'd0, 4'd0, 0, 1, 32'h301, 0, 0);
    cycle("ovf_clear_vs_set", 2'd2, 4'd6, 0, 1, 32'h302, 0, 0);
    mrc("ovf_status", 4'd6);
    do_reset("reset2");
    cycle("empty_push_pop", 2'd1, 4'd7, 0, 1, 32'h400, 0, 0);
    mrc("empty_pp_status", 4'd6);
    cycle("stall_mcr", 2'd2, 4'd2, 32'h7, 0, 0, 0, 1);
    cycle("stall_fault", 2'd0, 4'd0, 0, 1, 32'h500, 0, 1);
    mrc("after_stall", 4'd2);
    cycle("fault_a", 2'd0, 4'd0, 0, 1, 32'h600, 0, 0);
    cycle("fault_b", 2'd0, 4'd0, 0, 1, 32'h604, 0, 0);
    mrc("fault_addr", 4'd7);
    mcr("pend_clear", 4'd6, 0);
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 9));
      cycle("random", 2'($urandom_range(0, 3)), c > 4'd8 ? 4'd7 : c, $urandom(),
            $urandom_range(0, 9) < 3, $urandom(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0);
      if (i == 700) do_reset("random_reset");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/a23_copro15_ctrl.md
A23_COPRO15_CTRL -- requirements
Module: a23_copro15_ctrl

Interface
REQ-001 Parameter REGION_BITS, default 32: width of cacheable/updateable/disruptive area registers; each bit covers one 2MB region; 1..32.
REQ-002 Parameter FAULT_DEPTH, default 4: fault queue entries; power of two, 2..16.
REQ-003 Parameter ID_VALUE, default 32'h4156_0300: value returned by reads of CRn 0.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_fetch_stall  in  1  freezes all state updates and read data while high.
REQ-007 i_copro_operation  in  2  1=MRC (read), 2=MCR (write), other=idle.
REQ-008 i_copro_crn  in  4  register number.
REQ-009 i_copro_write_data  in  32  MCR data.
REQ-010 i_fault  in  1  latch a fault this cycle.
REQ-011 i_fault_status  in  8  fault status.
REQ-012 i_fault_address  in  32  faulting address.
REQ-013 i_cache_flush_ack  in  1  cache has finished the requested flush.
REQ-014 o_copro_read_data  out  32  registered MRC data.
REQ-015 o_cache_enable  out  1  cache_control[0].
REQ-016 o_cache_flush  out  1  flush request, level, held until acknowledged.
REQ-017 o_cacheable_area  out  REGION_BITS  cacheable region mask.
REQ-018 o_fault_pending  out  1  fault queue non-empty.

Function
REQ-019 No register update occurs on a cycle with i_fetch_stall high; o_copro_read_data holds.
REQ-020 MCR writes: CRn2 writes cache_control from data[2:0]; CRn3/4/5 write cacheable/updateable/disruptive from data[REGION_BITS-1:0]; CRn6 clears the overflow flag; other CRn values are ignored apart from REQ-021.
REQ-021 MCR to CRn1 sets flush_pending; o_cache_flush equals flush_pending.
REQ-022 i_cache_flush_ack clears flush_pending next cycle; the ack is honoured even during stall; ack while not pending is ignored.
REQ-023 MCR CRn1 while pending merges into the current request; MCR CRn1 coincident with ack leaves flush_pending set.
REQ-024 Read data is latched one cycle after the request, on every non-stalled cycle, from i_copro_crn: 0 ID_VALUE; 2 {29'd0,cache_control}; 3/4/5 area registers zero-extended; 6 {overflow, 19'd0, count[3:0], head_status[7:0]}; 7 head_address; others 0.
REQ-025 With the queue empty, head_status and head_address read as 0.
REQ-026 A push occurs when i_fault is high and not stalled; a pop occurs on MRC CRn7 that is not stalled and finds the queue non-empty.
REQ-027 The read data of a popping MRC CRn7 returns the pre-pop head.
REQ-028 A push into a full queue with no simultaneous pop is dropped and sets the sticky overflow flag; a push and pop together when full both take effect, count unchanged.
REQ-029 An empty-queue pop is a no-op; a push and pop together when empty performs the push only.
REQ-030 Count range is 0..FAULT_DEPTH; read and write pointers wrap modulo FAULT_DEPTH.
REQ-031 MCR CRn6 coincident with an overflowing push leaves overflow set.

Reset
REQ-032 Asynchronous reset clears cache_control, all area registers, flush_pending, overflow, pointers, count, queue contents and o_copro_read_data to 0.
REQ-033 Reset during a pending flush drops the request; the cache handles any late ack harmlessly per REQ-022.

Configuration
REQ-034 With A23_COPRO_FAULT_QUEUE_EN defined, the fault queue behaves per REQ-026..031.
REQ-035 With A23_COPRO_FAULT_QUEUE_EN undefined, a single fault register applies: the last fault wins, no pop, overflow and count read 0, and o_fault_pending is set by a fault and cleared by MCR CRn6.

Structure
REQ-036 Shared package a23_copro_pkg holds the operation encodings (COPRO_MRC=2'd1, COPRO_MCR=2'd2), CRn constants 0..7 and the ID_VALUE default.
REQ-037 The fault queue is sub-module a23_copro_fault_fifo (parameters WIDTH=40, DEPTH) with push/pop/full/empty/count ports.

Verification
REQ-038 Reset, then MRC CRn0 -> read data 32'h4156_0300 the next cycle; all outputs 0.
REQ-039 MCR CRn3 data 32'hFFFF_0001 with REGION_BITS=16 -> o_cacheable_area 16'h0001; MRC CRn3 -> 32'h0000_0001.
REQ-040 MCR CRn1 -> o_cache_flush 1 and held 5 cycles; MCR CRn1 again on the ack cycle -> o_cache_flush remains 1; second ack -> 0.
REQ-041 Five faults (addresses 0x100..0x104, DEPTH 4) -> CRn6 shows overflow=1, count=4; four MRC CRn7 return 0x100..0x103; fifth returns 0; o_fault_pending falls after the fourth.
REQ-042 Full queue: fault and MRC CRn7 in the same cycle -> count stays 4, overflow unchanged, read returns the old head.
REQ-043 i_fetch_stall high during MCR CRn2 and during i_fault -> no state change; macro undefined -> two faults leave CRn7 equal to the second address.
